// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial framing transmitter: state encoding and sync pattern.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_DATA  = 2'b10,
    ST_GUARD = 2'b11
  } state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         SYNC_LEN     = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; MSB is presented first, shift moves toward MSB.
module piso_shift_reg
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync 1-0-1, MSB-first payload, then guard zeros, with BUSY/DONE.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GUARD_LEN = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  // The counter also sequences the sync bits, so it must hold SYNC_LEN-1.
  localparam int CW = $clog2(max3(WIDTH, GUARD_LEN, SYNC_LEN)) + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          sout_n, busy_n, done_n;
  logic          load, shift, msb;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk  (CLK),
    .rst  (RESET),
    .load (load),
    .shift(shift),
    .din  (DATA),
    .msb  (msb)
  );

  // Next-state logic computes the value SOUT/BUSY/DONE will carry after the edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sout_n  = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (START) begin
          state_n = ST_SYNC;
          cnt_n   = '0;
          sout_n  = SYNC_PATTERN[SYNC_LEN-1];
          busy_n  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt == CW'(SYNC_LEN-1)) begin
          state_n = ST_DATA;
          cnt_n   = '0;
          sout_n  = msb;
          shift   = 1'b1;
        end else begin
          cnt_n  = cnt + CW'(1);
          sout_n = SYNC_PATTERN[2'(SYNC_LEN-2) - cnt[1:0]];
        end
      end
      ST_DATA: begin
        if (cnt == CW'(WIDTH-1)) begin
          state_n = ST_GUARD;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + CW'(1);
          sout_n = msb;
          shift  = 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt == CW'(GUARD_LEN-1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      SOUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      SOUT  <= sout_n;
      BUSY  <= busy_n;
      DONE  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: frame-level reference model compared every cycle, plus directed checks.
module tb_serial_frame_tx;

  localparam int WIDTH     = 8;
  localparam int GUARD_LEN = 2;
  localparam int F         = 3 + WIDTH + GUARD_LEN;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             START;
  logic [WIDTH-1:0] DATA;
  logic             SOUT, BUSY, DONE;

  int tests = 0;
  int fails = 0;

  // Reference model: position within the current frame (-1 when idle) and the frame's bit string.
  int           pos    = -1;
  logic         done_e = 1'b0;
  logic [F-1:0] fbits  = '0;
  logic [2:0]   hist   = '0;
  int           dets   = 0;

  serial_frame_tx #(.WIDTH(WIDTH), .GUARD_LEN(GUARD_LEN)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .START(START),
    .DATA (DATA),
    .SOUT (SOUT),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic exp_s;
    if (RESET) begin
      pos    = -1;
      done_e = 1'b0;
    end else if (pos >= 0) begin
      pos++;
      if (pos == F) begin
        pos    = -1;
        done_e = 1'b1;
      end else begin
        done_e = 1'b0;
      end
    end else begin
      done_e = 1'b0;
      if (START) begin
        pos   = 0;
        fbits = {3'b101, DATA, {GUARD_LEN{1'b0}}};
      end
    end
    @(posedge CLK);
    #1;
    exp_s = (pos >= 0) ? fbits[F-1-pos] : 1'b0;
    chk("sout", {31'd0, SOUT}, {31'd0, exp_s});
    chk("busy", {31'd0, BUSY}, {31'd0, pos >= 0});
    chk("done", {31'd0, DONE}, {31'd0, done_e});
    hist = {hist[1:0], SOUT};
    if (hist == 3'b101) dets++;
  endtask

  initial begin
    logic [F-1:0] obs;
    int bcnt, dcyc, idle_cnt, ones, dcount;

    // Reset held with START asserted: nothing may start
    RESET = 1'b1;
    START = 1'b1;
    DATA  = 8'h3C;
    repeat (2) step();
    chk("reset_sout", {31'd0, SOUT}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    RESET = 1'b0;
    START = 1'b0;
    step();

    // Single frame with payload A5
    obs  = '0;
    bcnt = 0;
    dcyc = 0;
    DATA  = 8'hA5;
    START = 1'b1;
    step();
    START = 1'b0;
    DATA  = 8'h5A;
    for (int c = 1; c <= F + 2; c++) begin
      if (c > 1) step();
      if (c <= F) obs = {obs[F-2:0], SOUT};
      bcnt += int'(BUSY);
      if (DONE) dcyc = c;
    end
    chk("frame_a5", 32'(obs), 32'(13'b1011010010100));
    chk("busy_len", bcnt, 13);
    chk("done_cycle", dcyc, 14);

    // START pulse mid-frame is ignored
    DATA  = WIDTH'($urandom);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (3) step();
    DATA  = 8'hFF;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (F + 3) step();
    chk("ignored_start_idle", {31'd0, BUSY}, 32'd0);

    // Back-to-back frames with START held
    DATA  = 8'hFF;
    START = 1'b1;
    step();
    DATA     = 8'h00;
    idle_cnt = 0;
    for (int k = 1; k <= F + 1; k++) begin
      step();
      if (!BUSY) idle_cnt++;
    end
    START = 1'b0;
    ones  = int'(SOUT);
    for (int k = 1; k < F; k++) begin
      step();
      ones += int'(SOUT);
    end
    chk("b2b_gap", idle_cnt, 1);
    chk("b2b_second_ones", ones, 2);
    repeat (3) step();

    // Reset during payload bit 3 aborts the frame without DONE
    DATA  = WIDTH'($urandom);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (7) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("abort_sout", {31'd0, SOUT}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    dcount = 0;
    for (int k = 0; k < F + 2; k++) begin
      step();
      dcount += int'(DONE);
    end
    chk("abort_no_done", dcount, 0);
    DATA  = WIDTH'($urandom);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (F + 2) step();

    // Randomized traffic, including START noise while busy
    for (int f = 0; f < 8; f++) begin
      DATA  = WIDTH'($urandom);
      START = 1'b1;
      step();
      repeat ($urandom_range(F + 1, F + 6)) begin
        START = ($urandom_range(0, 3) == 0);
        DATA  = WIDTH'($urandom);
        step();
      end
    end
    START = 1'b0;
    repeat (F + 3) step();

    // Loopback into a 101 detector: zero payloads give one detection per frame
    dets = 0;
    DATA = 8'h00;
    for (int f = 0; f < 3; f++) begin
      START = 1'b1;
      step();
      START = 1'b0;
      repeat (F) step();
    end
    repeat (2) step();
    chk("loopback_dets", dets, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
